// File: rtl/std_reg_pkg.sv
// Shared types for the std_reg write/readback initiator.
// Contents: FSM state enum, response status codes, and a status classification helper.
package std_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] STATUS_OK       = 2'd0;
  localparam logic [1:0] STATUS_MISMATCH = 2'd1;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'd2;

  // Any status other than OK counts toward the error statistic.
  function automatic logic is_error(input logic [1:0] status);
    return (status != STATUS_OK);
  endfunction

endpackage

// File: rtl/std_reg_writer_if.sv
// Bundle of request, register-side and response signals of std_reg_writer.
// master: the writer (std_reg_writer) side; slave: controller + register side.
// Signals: req_valid/req_data/req_ready (request handshake), reg_in/reg_write_en/
// reg_out/reg_done (register port), resp_valid/resp_status/resp_ready (response
// handshake), write_count/error_count (statistics).
interface std_reg_writer_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req_valid;
  logic [WIDTH-1:0] req_data;
  logic             req_ready;
  logic [WIDTH-1:0] reg_in;
  logic             reg_write_en;
  logic [WIDTH-1:0] reg_out;
  logic             reg_done;
  logic             resp_valid;
  logic [1:0]       resp_status;
  logic             resp_ready;
  logic [CNT_W-1:0] write_count;
  logic [CNT_W-1:0] error_count;

  modport master (
    input  req_valid, req_data, reg_out, reg_done, resp_ready,
    output req_ready, reg_in, reg_write_en, resp_valid, resp_status,
           write_count, error_count
  );

  modport slave (
    output req_valid, req_data, reg_out, reg_done, resp_ready,
    input  req_ready, reg_in, reg_write_en, resp_valid, resp_status,
           write_count, error_count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: increments on inc, sticks at all-ones.
// Ports: clk, reset (async active-low), inc (count enable), count (current value).
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Count register; holds once it reaches the maximum value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= {W{1'b0}};
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/std_reg_writer.sv
// Initiator for a std_reg: takes a write request, pulses write_en once, waits
// for done, reads back out and reports OK / MISMATCH / TIMEOUT on a held
// response handshake, while keeping saturating write and error counters.
// Ports: clk, reset (async active-low), bus (std_reg_writer_if.master).
module std_reg_writer
  import std_reg_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  std_reg_writer_if.master bus
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int             TW        = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  TCNT_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_status;
  logic [1:0]       w_next_status;
  logic [TW-1:0]    r_tcnt;
  logic             w_expired;
  logic             w_resp_accept;
  logic             w_inc_error;

  assign w_expired = (TIMEOUT != 0) && (r_tcnt == TCNT_LAST);

  // Next-state and status decision; done wins over a same-cycle expiry.
  always_comb begin
    w_next_state  = r_state;
    w_next_status = r_status;
    w_resp_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          w_next_state = ST_WRITE;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_WRITE: begin
        w_next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.reg_done) begin
          w_next_state  = ST_RESP;
          w_next_status = (bus.reg_out == r_data) ? STATUS_OK : STATUS_MISMATCH;
        end else if (w_expired) begin
          w_next_state  = ST_RESP;
          w_next_status = STATUS_TIMEOUT;
        end else begin
          w_next_state = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          w_next_state  = ST_IDLE;
          w_resp_accept = 1'b1;
        end else begin
          w_next_state = ST_RESP;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Latched write data, response status and WAIT-cycle counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data   <= {WIDTH{1'b0}};
      r_status <= STATUS_OK;
      r_tcnt   <= {TW{1'b0}};
    end else begin
      r_status <= w_next_status;
      if ((r_state == ST_IDLE) && bus.req_valid) begin
        r_data <= bus.req_data;
      end
      if (r_state == ST_WRITE) begin
        r_tcnt <= {TW{1'b0}};
      end else if ((r_state == ST_WAIT) && !bus.reg_done && !w_expired && (TIMEOUT != 0)) begin
        r_tcnt <= r_tcnt + TW'(1);
      end
    end
  end

  assign w_inc_error = w_resp_accept && is_error(r_status);

  // Outputs come straight from registers or state decode.
  assign bus.req_ready    = (r_state == ST_IDLE);
  assign bus.reg_write_en = (r_state == ST_WRITE);
  assign bus.resp_valid   = (r_state == ST_RESP);
  assign bus.reg_in       = r_data;
  assign bus.resp_status  = r_status;

  sat_counter #(.W(CNT_W)) u_write_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_resp_accept),
    .count (bus.write_count)
  );

  sat_counter #(.W(CNT_W)) u_error_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc_error),
    .count (bus.error_count)
  );

endmodule

// File: tb/tb_std_reg_writer.sv
// Self-checking bench for std_reg_writer. dut0: TIMEOUT=8, CNT_W=16.
// dut1: TIMEOUT=0, CNT_W=2 (saturation and endless wait).
module tb_std_reg_writer;

  localparam int TO0 = 8;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_pass;
  int   cyc;
  int   wen0;
  int   mode0;   // 0: faithful register, 1: reads back zero, 2: never done
  int   mode1;
  int   wc0;
  int   ec0;

  std_reg_writer_if #(.WIDTH(32), .CNT_W(16)) if0 ();
  std_reg_writer_if #(.WIDTH(32), .CNT_W(2))  if1 ();

  std_reg_writer #(.WIDTH(32), .TIMEOUT(TO0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );

  std_reg_writer #(.WIDTH(32), .TIMEOUT(0), .CNT_W(2)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural std_reg behind each DUT: latch on write_en, done one cycle later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      if0.reg_out  <= 32'h0;
      if0.reg_done <= 1'b0;
      if1.reg_out  <= 32'h0;
      if1.reg_done <= 1'b0;
    end else begin
      if0.reg_done <= if0.reg_write_en && (mode0 != 2);
      if (if0.reg_write_en) if0.reg_out <= (mode0 == 1) ? 32'h0 : if0.reg_in;
      if1.reg_done <= if1.reg_write_en && (mode1 != 2);
      if (if1.reg_write_en) if1.reg_out <= (mode1 == 1) ? 32'h0 : if1.reg_in;
    end
  end

  // Cycle and write_en pulse counters.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if0.reg_write_en) wen0 <= wen0 + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v >= maxv) ? maxv : v + 1;
  endfunction

  // One request on dut0; hold = cycles resp_ready stays low once the response is up.
  task automatic run0(input logic [31:0] data, input int mode, input int hold);
    logic [31:0] ret;
    logic [1:0]  exp_st;
    int          exp_lat;
    int          lat;
    int          wen_start;
    ret     = (mode == 1) ? 32'h0 : data;
    if (mode == 2)        exp_st = 2'd2;
    else if (ret == data) exp_st = 2'd0;
    else                  exp_st = 2'd1;
    exp_lat = (mode == 2) ? (2 + TO0) : 3;
    mode0 = mode;
    if0.resp_ready = (hold == 0);
    @(negedge clk);
    chk("req_ready_idle", if0.req_ready, 1);
    wen_start = wen0;
    if0.req_valid = 1'b1;
    if0.req_data  = data;
    @(posedge clk);
    #1;
    if0.req_valid = 1'b0;
    if0.req_data  = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("write_en", if0.reg_write_en, 1);
        chk("reg_in", if0.reg_in, data);
      end
    end while (!if0.resp_valid && lat < 40);
    chk("latency", lat, exp_lat);
    chk("status", if0.resp_status, exp_st);
    chk("reg_in_held", if0.reg_in, data);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", if0.resp_valid, 1);
      chk("bp_status", if0.resp_status, exp_st);
      chk("bp_req_ready", if0.req_ready, 0);
      chk("bp_wcount", if0.write_count, wc0);
    end
    chk("pre_wcount", if0.write_count, wc0);
    chk("pre_ecount", if0.error_count, ec0);
    if0.resp_ready = 1'b1;
    @(posedge clk);
    wc0 = sat_inc(wc0, 65535);
    if (exp_st != 2'd0) ec0 = sat_inc(ec0, 65535);
    @(negedge clk);
    chk("post_req_ready", if0.req_ready, 1);
    chk("post_valid", if0.resp_valid, 0);
    chk("wcount", if0.write_count, wc0);
    chk("ecount", if0.error_count, ec0);
    chk("wen_pulses", wen0 - wen_start, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    int acc[5];
    int n;
    int g;
    int seen;
    int wen_start;
    n_chk = 0; n_pass = 0; cyc = 0; wen0 = 0; mode0 = 0; mode1 = 0; wc0 = 0; ec0 = 0;
    reset = 1'b0;
    if0.req_valid = 1'b0; if0.req_data = 32'h0; if0.resp_ready = 1'b1;
    if1.req_valid = 1'b0; if1.req_data = 32'h0; if1.resp_ready = 1'b1;
    #2;
    chk("rst_req_ready", if0.req_ready, 1);
    chk("rst_write_en", if0.reg_write_en, 0);
    chk("rst_resp_valid", if0.resp_valid, 0);
    chk("rst_status", if0.resp_status, 0);
    chk("rst_reg_in", if0.reg_in, 0);
    chk("rst_counts", {if0.write_count, if0.error_count}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Basic, mismatch, timeout, backpressure.
    run0(32'hDEADBEEF, 0, 0);
    run0(32'h00000001, 1, 0);
    run0(32'h12345678, 2, 0);
    run0($urandom, 0, 10);
    for (int i = 0; i < 8; i++) run0($urandom, $urandom_range(0, 2), $urandom_range(0, 3));

    // Back-to-back with req_valid held high.
    mode0 = 0;
    if0.resp_ready = 1'b1;
    wen_start = wen0;
    n = 0; g = 0;
    @(negedge clk);
    if0.req_valid = 1'b1;
    if0.req_data  = $urandom;
    while (n < 5 && g < 60) begin
      if (if0.req_ready) begin
        acc[n] = cyc;
        n++;
      end
      if (n == 5) begin
        @(posedge clk);
        #1;
        if0.req_valid = 1'b0;
      end else begin
        @(negedge clk);
        g++;
        if0.req_data = $urandom;
      end
    end
    chk("b2b_accepts", n, 5);
    for (int i = 1; i < 5; i++) chk("b2b_spacing", acc[i] - acc[i-1], 4);
    g = 0;
    do begin @(negedge clk); g++; end while (!if0.req_ready && g < 20);
    for (int i = 0; i < 5; i++) wc0 = sat_inc(wc0, 65535);
    chk("b2b_wcount", if0.write_count, wc0);
    chk("b2b_ecount", if0.error_count, ec0);
    chk("b2b_wen", wen0 - wen_start, 5);

    // Asynchronous reset while waiting for done.
    mode0 = 2;
    @(negedge clk);
    if0.req_valid = 1'b1;
    if0.req_data  = 32'hA5A50F0F;
    @(posedge clk);
    #1;
    if0.req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("wait_req_ready", if0.req_ready, 0);
    reset = 1'b0;
    #1;
    chk("arst_req_ready", if0.req_ready, 1);
    chk("arst_write_en", if0.reg_write_en, 0);
    chk("arst_resp_valid", if0.resp_valid, 0);
    chk("arst_wcount", if0.write_count, 0);
    chk("arst_ecount", if0.error_count, 0);
    chk("arst_reg_in", if0.reg_in, 0);
    wc0 = 0; ec0 = 0;
    @(negedge clk);
    reset = 1'b1;
    run0($urandom, 0, 0);

    // Saturation on the 2-bit counters of dut1.
    mode1 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if1.req_valid = 1'b1;
      if1.req_data  = $urandom;
      @(posedge clk);
      #1;
      if1.req_valid = 1'b0;
      g = 0;
      do begin @(negedge clk); g++; end while (!if1.req_ready && g < 20);
      chk("sat_wcount", if1.write_count, (k + 1 > 3) ? 3 : k + 1);
    end
    chk("sat_ecount", if1.error_count, 0);

    // TIMEOUT=0: no done means the response never comes.
    mode1 = 2;
    seen = 0;
    @(negedge clk);
    if1.req_valid = 1'b1;
    if1.req_data  = $urandom;
    @(posedge clk);
    #1;
    if1.req_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (if1.resp_valid) seen = 1;
    end
    chk("noto_resp_valid", seen, 0);
    chk("noto_req_ready", if1.req_ready, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
